// File: rtl/rpn_stack_driver_if.sv
// rpn_stack_driver_if
//   Bundles the three channels around the RPN driver:
//   - token stream in (valid/ready)
//   - opcode/data out to the stack datapath, with its result/status back
//   - result out (valid/ready)
//   Modports:
//   - master: the driver's view
//   - slave: the view of the environment (token source, stack and result consumer)
//   Parameter DATA_WIDTH: operand/result width.
interface rpn_stack_driver_if #(parameter int DATA_WIDTH = 16);
   logic                  tok_valid;
   logic                  tok_ready;
   logic                  tok_is_op;
   logic [DATA_WIDTH-1:0] tok_data;
   logic                  tok_last;
   logic [2:0]            stk_opcode;
   logic [DATA_WIDTH-1:0] stk_data_in;
   logic [DATA_WIDTH-1:0] stk_data_out;
   logic                  stk_overflow;
   logic                  stk_full;
   logic                  stk_empty;
   logic                  res_valid;
   logic                  res_ready;
   logic [DATA_WIDTH-1:0] res_data;
   logic                  res_ovf;
   logic [1:0]            res_err;

   modport master (
      input  tok_valid, tok_is_op, tok_data, tok_last,
      output tok_ready,
      output stk_opcode, stk_data_in,
      input  stk_data_out, stk_overflow, stk_full, stk_empty,
      output res_valid, res_data, res_ovf, res_err,
      input  res_ready
   );

   modport slave (
      output tok_valid, tok_is_op, tok_data, tok_last,
      input  tok_ready,
      input  stk_opcode, stk_data_in,
      output stk_data_out, stk_overflow, stk_full, stk_empty,
      input  res_valid, res_data, res_ovf, res_err,
      output res_ready
   );
endinterface

// File: rtl/rpn_stack_driver.sv
// rpn_stack_driver
//   Initiator for a stack ALU. It takes RPN tokens and issues PUSH/ADD/MUL/POP
//   opcodes to the stack. It tracks the stack depth and returns one result per
//   expression.
//
//   Error checks run before an opcode is issued, so the offending opcode never
//   reaches the stack:
//   - UNDERFLOW: operator with fewer than 2 entries on the stack
//   - FULL: operand with the stack already full
//   - MALFORMED: expression ends with depth != 1, or the stack's full/empty
//     flags disagree with the depth counter
//
//   Ports:
//   - clk, rst: clock and synchronous active-high reset
//   - bus (master modport):
//     - tok_*: token stream in
//     - stk_*: opcode/data out, stack result/flags in
//     - res_*: result out, held until res_ready
//
//   Optional macro RPN_ERR_FLUSH_EN: on an error, pop the stack empty
//   (FLUSH state) before reporting. Without it, the stack is left as-is and
//   rst is needed to recover.
module rpn_stack_driver #(
   parameter int DATA_WIDTH  = 16,
   parameter int STACK_DEPTH = 16
) (
   input logic               clk,
   input logic               rst,
   rpn_stack_driver_if.master bus
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
   localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
   localparam logic [DW-1:0] DEPTH_TWO = DW'(2);

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_PUSH = 3'b110;
   localparam logic [2:0] OP_POP  = 3'b111;

   localparam logic [1:0] ERR_OK        = 2'b00;
   localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
   localparam logic [1:0] ERR_FULL      = 2'b10;
   localparam logic [1:0] ERR_MALFORMED = 2'b11;

   typedef enum logic [2:0] {
      ACCEPT, ISSUE, SAMPLE, POP, POPWAIT, REPORT, FLUSH
   } state_t;

   state_t                state, state_nxt, fail_state;
   logic [DW-1:0]         depth;
   logic                  op_q, last_q;
   logic [2:0]            opcode, op_nxt;
   logic [DATA_WIDTH-1:0] din, din_nxt;
   logic [DATA_WIDTH-1:0] res_data;
   logic                  res_ovf;
   logic [1:0]            res_err, err_code;
   logic                  err_set;
   logic                  tok_ready, tok_fire, flags_bad;

   assign tok_ready = (state == ACCEPT) && !rst;
   assign tok_fire  = bus.tok_valid && tok_ready;

   // Stack flags are only trusted as a cross-check against our own counter.
   assign flags_bad = (bus.stk_full && depth < DEPTH_MAX) ||
                      (bus.stk_empty && depth != '0);

`ifdef RPN_ERR_FLUSH_EN
   assign fail_state = (depth != '0) ? FLUSH : REPORT;
`else
   assign fail_state = REPORT;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= ACCEPT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      err_code  = ERR_OK;
      op_nxt    = OP_NOP;
      din_nxt   = '0;
      case (state)
         ACCEPT: if (tok_fire) begin
            if (!bus.tok_is_op && depth == DEPTH_MAX) begin
               err_set   = 1'b1;
               err_code  = ERR_FULL;
               state_nxt = fail_state;
            end else if (bus.tok_is_op && depth < DEPTH_TWO) begin
               err_set   = 1'b1;
               err_code  = ERR_UNDERFLOW;
               state_nxt = fail_state;
            end else begin
               state_nxt = ISSUE;
            end
         end
         ISSUE:   state_nxt = SAMPLE;
         SAMPLE: begin
            if (flags_bad || (last_q && depth != DEPTH_ONE)) begin
               err_set   = 1'b1;
               err_code  = ERR_MALFORMED;
               state_nxt = fail_state;
            end else if (last_q) begin
               state_nxt = POP;
            end else begin
               state_nxt = ACCEPT;
            end
         end
         POP:     state_nxt = POPWAIT;
         POPWAIT: state_nxt = REPORT;
         REPORT:  if (bus.res_ready) state_nxt = ACCEPT;
         // The POP issued in this cycle empties the last entry.
         FLUSH:   if (depth <= DEPTH_ONE) state_nxt = REPORT;
         default: state_nxt = ACCEPT;
      endcase

      // Opcode is computed from the next state so the stack sees a registered
      // opcode for exactly the ISSUE/POP/FLUSH cycles.
      if (state_nxt == ISSUE) begin
         if (bus.tok_is_op) op_nxt = bus.tok_data[0] ? OP_MUL : OP_ADD;
         else begin
            op_nxt  = OP_PUSH;
            din_nxt = bus.tok_data;
         end
      end else if (state_nxt == POP || state_nxt == FLUSH) begin
         op_nxt = OP_POP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         depth    <= '0;
         op_q     <= 1'b0;
         last_q   <= 1'b0;
         opcode   <= OP_NOP;
         din      <= '0;
         res_data <= '0;
         res_ovf  <= 1'b0;
         res_err  <= ERR_OK;
      end else begin
         opcode <= op_nxt;
         din    <= din_nxt;
         if (tok_fire) begin
            op_q   <= bus.tok_is_op;
            last_q <= bus.tok_last;
         end
         case (state)
            ISSUE:   depth <= op_q ? depth - DEPTH_ONE : depth + DEPTH_ONE;
            SAMPLE:  if (op_q) res_ovf <= res_ovf | bus.stk_overflow;
            POP:     depth <= '0;
            POPWAIT: res_data <= bus.stk_data_out;
            FLUSH:   if (depth != '0) depth <= depth - DEPTH_ONE;
            REPORT:  if (bus.res_ready) begin
               res_data <= '0;
               res_ovf  <= 1'b0;
               res_err  <= ERR_OK;
            end
            default: ;
         endcase
         if (err_set) res_err <= err_code;
      end
   end

   assign bus.tok_ready   = tok_ready;
   assign bus.stk_opcode  = opcode;
   assign bus.stk_data_in = din;
   assign bus.res_valid   = (state == REPORT);
   assign bus.res_data    = res_data;
   assign bus.res_ovf     = res_ovf;
   assign bus.res_err     = res_err;
endmodule
